// File: rtl/reservoir_sequencer.sv
// Time-multiplexed LIF reservoir sequencer: injects each 32-bit bitstream word MSB-first,
// strobes one neuron per slot, counts returned spikes and emits one count frame per sample.
module reservoir_sequencer #(
  parameter int N_NEURONS = 10,
  parameter int BITS      = 32,
  parameter int CW        = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [15:0]             num_samples,
  input  logic [BITS-1:0]         bitstream_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bit_out,
  output logic [N_NEURONS-1:0]    neuron_en,
  input  logic [N_NEURONS-1:0]    spike_in,
  output logic [N_NEURONS*CW-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int BIW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int SW  = $clog2(N_NEURONS + 1);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(BITS - 1);
  localparam logic [SW-1:0]  LAST_SLOT = SW'(N_NEURONS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_INJECT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     nsamp_q, nsamp_d;
  logic [15:0]     samp_cnt_q, samp_cnt_d;
  logic [BITS-1:0] word_q, word_d;
  logic [BIW-1:0]  bit_idx_q, bit_idx_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [CW-1:0]   cnt_q [N_NEURONS];
  logic [CW-1:0]   cnt_d [N_NEURONS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      nsamp_q    <= '0;
      samp_cnt_q <= '0;
      word_q     <= '0;
      bit_idx_q  <= '0;
      slot_q     <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      nsamp_q    <= nsamp_d;
      samp_cnt_q <= samp_cnt_d;
      word_q     <= word_d;
      bit_idx_q  <= bit_idx_d;
      slot_q     <= slot_d;
      for (int k = 0; k < N_NEURONS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    nsamp_d    = nsamp_q;
    samp_cnt_d = samp_cnt_q;
    word_d     = word_q;
    bit_idx_d  = bit_idx_q;
    slot_d     = slot_q;
    for (int k = 0; k < N_NEURONS; k++) begin
      cnt_d[k] = cnt_q[k];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_samples == 16'd0) begin
            state_d = S_DONE;
          end else begin
            nsamp_d    = num_samples;
            samp_cnt_d = '0;
            state_d    = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (sample_valid) begin
          word_d    = bitstream_in;
          bit_idx_d = '0;
          slot_d    = '0;
          for (int k = 0; k < N_NEURONS; k++) begin
            cnt_d[k] = '0;
          end
          state_d = S_INJECT;
        end
      end
      S_INJECT: begin
        // A neuron strobed in slot s answers one cycle later, i.e. during slot s+1.
        for (int k = 0; k < N_NEURONS; k++) begin
          if (slot_q == SW'(k + 1) && spike_in[k]) begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
        if (slot_q == LAST_SLOT) begin
          slot_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_EMIT;
          end else begin
            bit_idx_d = bit_idx_q + BIW'(1);
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      S_EMIT: begin
        if (frame_ready) begin
          samp_cnt_d = samp_cnt_q + 16'd1;
          state_d    = (samp_cnt_d == nsamp_q) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort freezes every register except the state; counts and word stay stale.
    if (abort) begin
      state_d    = S_IDLE;
      nsamp_d    = nsamp_q;
      samp_cnt_d = samp_cnt_q;
      word_d     = word_q;
      bit_idx_d  = bit_idx_q;
      slot_d     = slot_q;
      for (int k = 0; k < N_NEURONS; k++) begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  always_comb begin
    sample_ready = (state_q == S_FETCH);
    frame_valid  = (state_q == S_EMIT);
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    bit_out      = 1'b0;
    neuron_en    = '0;
    frame_data   = '0;
    if (state_q == S_INJECT) begin
      bit_out = word_q[LAST_BIT - bit_idx_q];
      for (int k = 0; k < N_NEURONS; k++) begin
        neuron_en[k] = (slot_q == SW'(k));
      end
    end
    if (state_q == S_EMIT) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        frame_data[k*CW +: CW] = cnt_q[k];
      end
    end
  end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Self-checking bench for reservoir_sequencer: directed scenarios with randomized words,
// spikes and stalls, checked against a slot/bit arithmetic reference model.
module tb_reservoir_sequencer;
  localparam int N     = 10;
  localparam int B     = 32;
  localparam int C     = 6;
  localparam int SLOTS = N + 1;
  localparam int INJ   = B * SLOTS;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [15:0]    num_samples = '0;
  logic [B-1:0]   bitstream_in = '0;
  logic           sample_valid = 1'b0;
  logic           sample_ready;
  logic           bit_out;
  logic [N-1:0]   neuron_en;
  logic [N-1:0]   spike_in = '0;
  logic [N*C-1:0] frame_data;
  logic           frame_valid;
  logic           frame_ready = 1'b0;
  logic           busy;
  logic           done;

  reservoir_sequencer #(.N_NEURONS(N), .BITS(B), .CW(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_samples  (num_samples),
    .bitstream_in (bitstream_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bit_out      (bit_out),
    .neuron_en    (neuron_en),
    .spike_in     (spike_in),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int frames = 0;
  logic [N-1:0] spk [INJ];

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (frame_valid && frame_ready) frames <= frames + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count of neuron k = spikes presented on line k in the slot right after its strobe, summed over all bits.
  function automatic logic [63:0] model_frame();
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < N; k++) begin
      int sum;
      sum = 0;
      for (int b = 0; b < B; b++) begin
        if (spk[b*SLOTS + k + 1][k]) sum++;
      end
      f[k*C +: C] = C'(sum);
    end
    return f;
  endfunction

  task automatic do_start(input logic [15:0] n);
    num_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic inject_phase(input logic [B-1:0] word, input int mode, input int vdelay,
                              input int poke_at);
    int bad_bit, bad_en, bad_ctl;
    logic prev3, exp_bit;
    logic [N-1:0] exp_en;
    bad_bit = 0; bad_en = 0; bad_ctl = 0; prev3 = 1'b0;
    chk("fetch_ready", 64'(sample_ready), 64'd1);
    for (int i = 0; i < vdelay; i++) begin
      spike_in = (mode == 1) ? N'($urandom) : '0;
      tick();
      if (sample_ready !== 1'b1) bad_ctl++;
    end
    sample_valid = 1'b1;
    bitstream_in = word;
    tick();
    sample_valid = 1'b0;
    bitstream_in = $urandom;
    for (int c = 0; c < INJ; c++) begin
      exp_bit = word[B - 1 - c / SLOTS];
      exp_en = '0;
      if (c % SLOTS < N) exp_en[c % SLOTS] = 1'b1;
      if (bit_out !== exp_bit) bad_bit++;
      if (neuron_en !== exp_en) bad_en++;
      if (sample_ready !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad_ctl++;
      case (mode)
        1: spike_in = N'($urandom);
        2: begin
          spike_in = '0;
          spike_in[3] = prev3;
          spike_in[7] = 1'b1;
        end
        default: spike_in = '0;
      endcase
      prev3 = neuron_en[3];
      spk[c] = spike_in;
      start = (c == poke_at);
      if (c == poke_at) num_samples = 16'd1;
      tick();
    end
    start = 1'b0;
    spike_in = '0;
    chk("bit_out_seq", 64'(bad_bit), 64'd0);
    chk("neuron_en_seq", 64'(bad_en), 64'd0);
    chk("inject_ctl", 64'(bad_ctl), 64'd0);
    chk("frame_valid_rise", 64'(frame_valid), 64'd1);
    chk("frame_data", 64'(frame_data), model_frame());
  endtask

  task automatic emit_phase(input int stall, input bit last, input int mode);
    logic [63:0] held;
    int bad;
    held = 64'(frame_data);
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      frame_ready = 1'b0;
      spike_in = (mode == 1) ? N'($urandom) : '0;
      tick();
      if (frame_valid !== 1'b1 || 64'(frame_data) !== held) bad++;
    end
    chk("emit_hold", 64'(bad), 64'd0);
    spike_in = '0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    if (last) begin
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_busy", 64'(busy), 64'd1);
      tick();
      chk("done_clear", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end else begin
      chk("next_fetch", 64'(sample_ready), 64'd1);
      chk("no_early_done", 64'(done), 64'd0);
    end
  endtask

  initial begin
    int d0, f0, n;
    #12;
    chk("rst_frame_data", 64'(frame_data), 64'd0);
    chk("rst_ctl", 64'({sample_ready, bit_out, neuron_en, frame_valid, busy, done}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_after_rst", 64'(busy), 64'd0);

    // Bit order and latency with a silent reservoir.
    do_start(16'd1);
    inject_phase(32'h8000_0001, 0, 0, -1);
    chk("zero_counts", 64'(frame_data), 64'd0);
    emit_phase(0, 1'b1, 0);

    // Neuron 3 echoes its strobe, neuron 7 always high.
    do_start(16'd1);
    inject_phase($urandom, 2, 0, -1);
    chk("count3", 64'(frame_data[3*C +: C]), 64'd32);
    chk("count7", 64'(frame_data[7*C +: C]), 64'd32);
    chk("frame_23_18", 64'(frame_data[23:18]), 64'd32);
    emit_phase(0, 1'b1, 2);

    // Three samples with back-pressure, late input, and a start pulse while busy.
    d0 = done_cnt;
    f0 = frames;
    do_start(16'd3);
    for (int s = 0; s < 3; s++) begin
      inject_phase($urandom, 1, 5, (s == 1) ? 100 : -1);
      emit_phase(20, s == 2, 1);
    end
    chk("three_frames", 64'(frames - f0), 64'd3);
    chk("one_done", 64'(done_cnt - d0), 64'd1);

    // Randomized runs.
    for (int r = 0; r < 2; r++) begin
      n = int'($urandom_range(1, 2));
      do_start(16'(n));
      for (int s = 0; s < n; s++) begin
        inject_phase($urandom, 1, int'($urandom_range(0, 3)), -1);
        emit_phase(int'($urandom_range(0, 3)), s == n - 1, 1);
      end
    end

    // Empty run goes straight to DONE.
    num_samples = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_run_done", 64'(done), 64'd1);
    chk("zero_run_no_ready", 64'(sample_ready), 64'd0);
    tick();
    chk("zero_run_idle", 64'({busy, done}), 64'd0);

    // Abort while a frame is pending.
    d0 = done_cnt;
    do_start(16'd2);
    inject_phase($urandom, 1, 0, -1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_fv", 64'(frame_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_frame_data", 64'(frame_data), 64'd0);
    repeat (3) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Asynchronous reset in the middle of sample 1 of 3.
    d0 = done_cnt;
    do_start(16'd3);
    sample_valid = 1'b1;
    bitstream_in = $urandom;
    tick();
    sample_valid = 1'b0;
    repeat (50) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_frame_data", 64'(frame_data), 64'd0);
    chk("async_rst_ctl", 64'({sample_ready, bit_out, neuron_en, frame_valid, busy, done}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_idle", 64'(busy), 64'd0);
    do_start(16'd1);
    inject_phase($urandom, 1, 2, -1);
    emit_phase(3, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
